maxnet_loader: RTL and testbench

Input staging stage directly upstream of the Maxnet controller/datapath. Accepts N signed activation words serially over a valid/ready handshake, clamps negatives to zero, and holds them as a parallel vector for the datapath's initial-value load. Issues a single-cycle `start` pulse to the controller, then blocks new input until the network reports completion. An all-zero frame is rejected without starting the network.

---
 rtl/maxnet_pkg.sv | 25 ++
 rtl/maxnet_loader_if.sv | 14 +
 rtl/maxnet_loader.sv | 117 +++++++++++
 tb/tb_maxnet_loader.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/maxnet_pkg.sv
// Shared Maxnet definitions: loader and controller state encodings,
// default geometry and the slot-counter width helper.
package maxnet_pkg;

    localparam int N_DEF = 4;
    localparam int W_DEF = 8;

    typedef enum logic [1:0] {
        LD_IDLE  = 2'd0,
        LD_FILL  = 2'd1,
        LD_START = 2'd2,
        LD_WAIT  = 2'd3
    } ld_state_e;

    typedef enum logic [1:0] {
        CT_INIT = 2'd0,
        CT_RUN  = 2'd1,
        CT_DONE = 2'd2
    } ct_state_e;

    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/maxnet_loader_if.sv
// Serial activation stream into the Maxnet loader.
// Plain valid/ready: a word moves when both are high at a rising edge.
interface maxnet_loader_if
    import maxnet_pkg::*;
#(
    parameter int W = W_DEF
);
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/maxnet_loader.sv
// Maxnet input staging: serial words clamped at zero into a parallel
// vector, then a one-cycle start and a hold until the network finishes.
module maxnet_loader
    import maxnet_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    maxnet_loader_if.slave up,
    output logic           start,
    input  logic           net_done,
    output logic [N*W-1:0] x_out,
    output logic           busy,
    output logic           zero_err
);

    localparam int            CW   = cnt_w(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    ld_state_e     r_state;
    ld_state_e     w_nxt_state;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_nxt_cnt;
    logic          r_nz;
    logic          w_nxt_nz;
    logic [W-1:0]  r_x [N];
    logic          r_start;
    logic          r_busy;
    logic          r_zero_err;
    logic          w_zero_err;
    logic          w_ready;
    logic          w_acc;
    logic          w_last;
    logic          w_any;
    logic [W-1:0]  w_word;

    assign w_ready     = (r_state == LD_IDLE) || (r_state == LD_FILL);
    assign up.in_ready = w_ready;
    assign w_acc       = up.in_valid & w_ready;
    assign w_word      = up.in_data[W-1] ? '0 : up.in_data;
    // cnt is always 0 in IDLE, so this also covers N = 1
    assign w_last      = (r_cnt == LAST);
    assign w_any       = (w_word != '0) | ((r_state == LD_FILL) & r_nz);

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_nxt_nz    = r_nz;
        w_zero_err  = 1'b0;
        unique case (r_state)
            LD_IDLE, LD_FILL: begin
                if (w_acc) begin
                    w_nxt_nz = w_any;
                    if (w_last) begin
                        w_nxt_cnt = '0;
                        if (w_any) begin
                            w_nxt_state = LD_START;
                        end else begin
                            w_zero_err  = 1'b1;
                            w_nxt_state = LD_IDLE;
                        end
                    end else begin
                        w_nxt_cnt   = r_cnt + 1'b1;
                        w_nxt_state = LD_FILL;
                    end
                end
            end
            LD_START: w_nxt_state = LD_WAIT;
            LD_WAIT: begin
                if (net_done) begin
                    w_nxt_state = LD_IDLE;
                    w_nxt_cnt   = '0;
                end
            end
            default: w_nxt_state = LD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= LD_IDLE;
            r_cnt      <= '0;
            r_nz       <= 1'b0;
            r_start    <= 1'b0;
            r_busy     <= 1'b0;
            r_zero_err <= 1'b0;
        end else begin
            r_state    <= w_nxt_state;
            r_cnt      <= w_nxt_cnt;
            r_nz       <= w_nxt_nz;
            r_start    <= (w_nxt_state == LD_START);
            r_busy     <= (w_nxt_state == LD_WAIT);
            r_zero_err <= w_zero_err;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
                r_x[k] <= '0;
            end
        end else if (w_acc) begin
            r_x[r_cnt] <= w_word;
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_flat
        assign x_out[k*W +: W] = r_x[k];
    end

    assign start    = r_start;
    assign busy     = r_busy;
    assign zero_err = r_zero_err;

endmodule

// File: tb/tb_maxnet_loader.sv
// Directed and randomized frames for maxnet_loader against a
// frame-level reference model.
module tb_maxnet_loader;
    import maxnet_pkg::*;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start;
    logic           net_done = 1'b0;
    logic           busy;
    logic           zero_err;
    logic [N*W-1:0] x_out;

    maxnet_loader_if #(.W(W)) u_if ();

    maxnet_loader #(.N(N), .W(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .up      (u_if),
        .start   (start),
        .net_done(net_done),
        .x_out   (x_out),
        .busy    (busy),
        .zero_err(zero_err)
    );

    always #5 clk = ~clk;

    int           vectors = 0;
    int           miscompares = 0;
    logic [W-1:0] m_x [N];
    int           m_pos = 0;

    function automatic logic [W-1:0] clamp(input logic [W-1:0] w);
        return ($signed(w) < 0) ? '0 : w;
    endfunction

    function automatic logic [N*W-1:0] m_vec();
        logic [N*W-1:0] v;
        for (int k = 0; k < N; k++) v[k*W +: W] = m_x[k];
        return v;
    endfunction

    function automatic logic [W-1:0] rnd_word();
        int sel;
        sel = $urandom_range(0, 3);
        if (sel == 0) return '0;
        if (sel == 1) return 8'h80 | W'($urandom);
        return W'($urandom);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) m_x[k] = '0;
        m_pos = 0;
    endtask

    task automatic send_word(input logic [W-1:0] d);
        u_if.in_valid = 1'b1;
        u_if.in_data  = d;
        chk("in_ready_on_send", 64'(u_if.in_ready), 64'd1);
        @(negedge clk);
        m_x[m_pos] = clamp(d);
        m_pos++;
        u_if.in_valid = 1'b0;
    endtask

    task automatic stall(input int n, input bit spur);
        for (int i = 0; i < n; i++) begin
            net_done = spur && (i == 0);
            @(negedge clk);
            net_done = 1'b0;
            chk("stall_x_hold", 64'(x_out), 64'(m_vec()));
            chk("stall_ready", 64'(u_if.in_ready), 64'd1);
            chk("stall_no_start", 64'(start), 64'd0);
            chk("stall_not_busy", 64'(busy), 64'd0);
        end
    endtask

    task automatic frame(input logic [N*W-1:0] f, input int stall_at,
                         input int stall_n, input bit spur,
                         output bit started);
        bit any;
        any = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (k == stall_at) stall(stall_n, spur);
            send_word(f[k*W +: W]);
            any = any | (clamp(f[k*W +: W]) != '0);
        end
        m_pos = 0;
        chk("frame_x_out", 64'(x_out), 64'(m_vec()));
        if (any) begin
            chk("start_pulse", 64'(start), 64'd1);
            chk("no_zero_err", 64'(zero_err), 64'd0);
            chk("ready_low_start", 64'(u_if.in_ready), 64'd0);
            chk("busy_low_start", 64'(busy), 64'd0);
            @(negedge clk);
            chk("start_dropped", 64'(start), 64'd0);
            chk("busy_high", 64'(busy), 64'd1);
            chk("ready_low_wait", 64'(u_if.in_ready), 64'd0);
        end else begin
            chk("zero_err_pulse", 64'(zero_err), 64'd1);
            chk("zero_no_start", 64'(start), 64'd0);
            chk("zero_ready", 64'(u_if.in_ready), 64'd1);
            @(negedge clk);
            chk("zero_err_single", 64'(zero_err), 64'd0);
            chk("zero_no_start2", 64'(start), 64'd0);
            chk("zero_not_busy", 64'(busy), 64'd0);
        end
        started = any;
    endtask

    task automatic run_net(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            chk("wait_busy", 64'(busy), 64'd1);
            chk("wait_ready", 64'(u_if.in_ready), 64'd0);
            chk("wait_no_start", 64'(start), 64'd0);
            chk("wait_x_hold", 64'(x_out), 64'(m_vec()));
        end
        net_done = 1'b1;
        @(negedge clk);
        net_done = 1'b0;
        chk("done_busy_low", 64'(busy), 64'd0);
        chk("done_ready", 64'(u_if.in_ready), 64'd1);
    endtask

    task automatic async_reset();
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk("rst_x_out", 64'(x_out), 64'd0);
        chk("rst_start", 64'(start), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_zero_err", 64'(zero_err), 64'd0);
        chk("rst_ready", 64'(u_if.in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        bit             s;
        logic [N*W-1:0] f;
        u_if.in_valid = 1'b0;
        u_if.in_data  = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_x_out", 64'(x_out), 64'd0);
        chk("reset_start", 64'(start), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_zero_err", 64'(zero_err), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("reset_ready", 64'(u_if.in_ready), 64'd1);

        frame({8'h7F, 8'h05, 8'h20, 8'h10}, -1, 0, 1'b0, s);
        chk("basic_const", 64'(x_out), 64'h7F052010);
        run_net(3);

        frame({8'h81, 8'h03, 8'hFF, 8'h80}, -1, 0, 1'b0, s);
        chk("clamp_const", 64'(x_out), 64'h00030000);
        chk("clamp_started", 64'(s), 64'd1);
        run_net(2);

        frame({8'h80, 8'h00, 8'hF0, 8'h00}, -1, 0, 1'b0, s);
        chk("zero_not_started", 64'(s), 64'd0);

        for (int k = 0; k < N; k++) f[k*W +: W] = W'($urandom_range(1, 127));
        frame(f, 2, 5, 1'b1, s);
        run_net(4);

        for (int k = 0; k < N; k++) f[k*W +: W] = W'($urandom_range(1, 127));
        frame(f, -1, 0, 1'b0, s);
        @(negedge clk);
        async_reset();
        for (int k = 0; k < N; k++) f[k*W +: W] = rnd_word();
        f[7:0] = 8'h11;
        frame(f, -1, 0, 1'b0, s);
        run_net(2);

        send_word(8'h33);
        send_word(8'h44);
        async_reset();
        frame({8'h04, 8'h03, 8'h02, 8'h01}, -1, 0, 1'b0, s);
        chk("post_rst_frame", 64'(x_out), 64'h04030201);
        run_net(1);

        frame({8'h0A, 8'h0B, 8'h0C, 8'h0D}, -1, 0, 1'b0, s);
        run_net(1);
        frame({8'h1A, 8'hEB, 8'h1C, 8'h1D}, -1, 0, 1'b0, s);
        chk("b2b_second", 64'(x_out), 64'h1A001C1D);
        run_net(2);

        for (int t = 0; t < 12; t++) begin
            for (int k = 0; k < N; k++) f[k*W +: W] = rnd_word();
            frame(f, $urandom_range(0, 4), $urandom_range(0, 3),
                  1'($urandom_range(0, 1)), s);
            if (s) run_net($urandom_range(0, 5));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
